// File: rtl/display7seg_pkg.sv
// ============================================================================
// display7seg_pkg : shared constants, phase type and BCD-to-segment lookup
// Revision 1.0
// ============================================================================
`default_nettype none

package display7seg_pkg;

    localparam int BCD_W = 4;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0   = 7'b1000000;
    localparam logic [6:0] SEG_1   = 7'b1111001;
    localparam logic [6:0] SEG_2   = 7'b0100100;
    localparam logic [6:0] SEG_3   = 7'b0110000;
    localparam logic [6:0] SEG_4   = 7'b0011001;
    localparam logic [6:0] SEG_5   = 7'b0010010;
    localparam logic [6:0] SEG_6   = 7'b0000010;
    localparam logic [6:0] SEG_7   = 7'b1111000;
    localparam logic [6:0] SEG_8   = 7'b0000000;
    localparam logic [6:0] SEG_9   = 7'b0010000;
    localparam logic [6:0] SEG_OFF = 7'b1111111;

    typedef enum logic {
        PH_VISIBLE = 1'b0,
        PH_OFF     = 1'b1
    } phase_e;

    function automatic logic [6:0] bcd_to_seg(input logic [BCD_W-1:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_OFF;
        endcase
        return seg;
    endfunction

endpackage

`default_nettype wire

// File: rtl/display7seg_mux_if.sv
// ============================================================================
// display7seg_mux_if : controller-to-display bundle (value/strobes in, pins out)
// Revision 1.0
// ============================================================================
`default_nettype none

interface display7seg_mux_if #(
    parameter int DIGITS = 4
);
    import display7seg_pkg::*;

    logic [BCD_W*DIGITS-1:0] value;
    logic                    load;
    logic [DIGITS-1:0]       blank_mask;
    logic                    blink_en;
    logic [6:0]              seg;
    logic [DIGITS-1:0]       an;
    logic                    frame_done;

    modport master (
        output value, load, blank_mask, blink_en,
        input  seg, an, frame_done
    );

    modport slave (
        input  value, load, blank_mask, blink_en,
        output seg, an, frame_done
    );

endinterface

`default_nettype wire

// File: rtl/seg7_decode.sv
// ============================================================================
// seg7_decode : combinational BCD digit to active-low segment pattern
// Revision 1.0
// ============================================================================
`default_nettype none

module seg7_decode
    import display7seg_pkg::*;
(
    input  wire logic [BCD_W-1:0] digit_i,
    output logic      [6:0]       seg_o
);

    assign seg_o = bcd_to_seg(digit_i);

endmodule

`default_nettype wire

// File: rtl/display7seg_mux.sv
// ============================================================================
// display7seg_mux : time-multiplexed 7-segment scanner with tear-free shadow,
//                   leading-zero blanking, per-digit mask and whole-display blink
// Revision 1.0
// ============================================================================
`default_nettype none

module display7seg_mux
    import display7seg_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 64,
    parameter int LZ_BLANK     = 1
) (
    input  wire logic         clk,
    input  wire logic         reset,
    display7seg_mux_if.slave  bus
);

    localparam int VAL_W  = BCD_W * DIGITS;
    localparam int CNT_W  = $clog2(SCAN_DIV);
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int FCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);
    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(BLINK_FRAMES - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic [IDX_W-1:0]  idx_q,       idx_d;
    logic [VAL_W-1:0]  pending_q,   pending_d;
    logic              pend_q,      pend_d;
    logic [VAL_W-1:0]  shadow_q,    shadow_d;
    logic [FCNT_W-1:0] fcnt_q,      fcnt_d;
    phase_e            phase_q,     phase_d;
    logic              frame_end_q;
    logic [6:0]        seg_q,       seg_d;
    logic [DIGITS-1:0] an_q,        an_d;
    logic              frame_done_q;

    logic              w_slot_end;
    logic              w_frame_end;
    logic [BCD_W-1:0]  w_digit;
    logic [6:0]        w_dec_seg;
    logic [DIGITS-1:0] w_lz_dark;
    logic              w_zero_above;
    logic              w_lz_sel;
    logic              w_mask_sel;
    logic              w_dark;

    assign w_slot_end  = (cnt_q == CNT_LAST);
    assign w_frame_end = w_slot_end && (idx_q == IDX_LAST);

    // ------------------------------------------------------------------
    // Slot counter and digit index
    // ------------------------------------------------------------------
    always_comb begin : p_scan
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (w_slot_end) begin
            cnt_d = '0;
            if (idx_q == IDX_LAST) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Pending / shadow transfer; a load on the boundary cycle bypasses pending
    // ------------------------------------------------------------------
    always_comb begin : p_shadow
        pending_d = pending_q;
        pend_d    = pend_q;
        shadow_d  = shadow_q;
        if (bus.load) begin
            pending_d = bus.value;
            pend_d    = 1'b1;
        end
        if (w_frame_end) begin
            if (bus.load) begin
                shadow_d = bus.value;
                pend_d   = 1'b0;
            end else if (pend_q) begin
                shadow_d = pending_q;
                pend_d   = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Blink phase: counts frames regardless of blink_en
    // ------------------------------------------------------------------
    always_comb begin : p_blink
        fcnt_d  = fcnt_q;
        phase_d = phase_q;
        if (w_frame_end) begin
            if (fcnt_q == FCNT_LAST) begin
                fcnt_d  = '0;
                phase_d = (phase_q == PH_VISIBLE) ? PH_OFF : PH_VISIBLE;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Leading-zero detection, walking down from the most significant digit
    // ------------------------------------------------------------------
    always_comb begin : p_lz
        w_lz_dark    = '0;
        w_zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            w_zero_above = w_zero_above && (shadow_q[i*BCD_W +: BCD_W] == '0);
            w_lz_dark[i] = (LZ_BLANK != 0) && w_zero_above;
        end
    end

    // ------------------------------------------------------------------
    // Per-slot selection of digit, blanking flags and anode
    // ------------------------------------------------------------------
    always_comb begin : p_select
        w_digit    = '0;
        w_lz_sel   = 1'b0;
        w_mask_sel = 1'b0;
        an_d       = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                w_digit    = shadow_q[i*BCD_W +: BCD_W];
                w_lz_sel   = w_lz_dark[i];
                w_mask_sel = bus.blank_mask[i];
                an_d[i]    = 1'b0;
            end
        end
    end

    seg7_decode u_decode (
        .digit_i (w_digit),
        .seg_o   (w_dec_seg)
    );

    always_comb begin : p_seg
        w_dark = w_lz_sel || w_mask_sel || (bus.blink_en && (phase_q == PH_OFF));
        seg_d  = w_dark ? SEG_OFF : w_dec_seg;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            pending_q    <= '0;
            pend_q       <= 1'b0;
            shadow_q     <= '0;
            fcnt_q       <= '0;
            phase_q      <= PH_VISIBLE;
            frame_end_q  <= 1'b0;
            seg_q        <= SEG_OFF;
            an_q         <= '1;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pending_q    <= pending_d;
            pend_q       <= pend_d;
            shadow_q     <= shadow_d;
            fcnt_q       <= fcnt_d;
            phase_q      <= phase_d;
            // Delayed once so the pulse lines up with digit 0's first output cycle
            frame_end_q  <= w_frame_end;
            seg_q        <= seg_d;
            an_q         <= an_d;
            frame_done_q <= frame_end_q;
        end
    end

    assign bus.seg        = seg_q;
    assign bus.an         = an_q;
    assign bus.frame_done = frame_done_q;

endmodule

`default_nettype wire

// File: tb/tb_display7seg_mux.sv
// ============================================================================
// tb_display7seg_mux : directed self-checking bench for display7seg_mux
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_display7seg_mux;

    localparam int DIGITS       = 4;
    localparam int SCAN_DIV     = 4;
    localparam int BLINK_FRAMES = 2;
    localparam int LZ_BLANK     = 1;

    localparam logic [6:0] S0   = 7'b1000000;
    localparam logic [6:0] S1   = 7'b1111001;
    localparam logic [6:0] S2   = 7'b0100100;
    localparam logic [6:0] S3   = 7'b0110000;
    localparam logic [6:0] S4   = 7'b0011001;
    localparam logic [6:0] S5   = 7'b0010010;
    localparam logic [6:0] S6   = 7'b0000010;
    localparam logic [6:0] S7   = 7'b1111000;
    localparam logic [6:0] S8   = 7'b0000000;
    localparam logic [6:0] S9   = 7'b0010000;
    localparam logic [6:0] SOFF = 7'b1111111;

    logic clk;
    logic reset;
    int   cyc;
    int   n_checks;
    int   n_pass;
    int   n_fail;

    display7seg_mux_if #(.DIGITS(DIGITS)) bus ();

    display7seg_mux #(
        .DIGITS       (DIGITS),
        .SCAN_DIV     (SCAN_DIV),
        .BLINK_FRAMES (BLINK_FRAMES),
        .LZ_BLANK     (LZ_BLANK)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic wait_frame();
        int n;
        n = 0;
        while (bus.frame_done !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk("frame_wait", {31'd0, bus.frame_done}, 32'd1);
    endtask

    // Checks one whole output frame starting at the current cycle
    task automatic check_frame(input logic fd_first, input logic [6:0] e0, input logic [6:0] e1,
                               input logic [6:0] e2, input logic [6:0] e3);
        logic [6:0] ex [4];
        ex[0] = e0; ex[1] = e1; ex[2] = e2; ex[3] = e3;
        for (int d = 0; d < 4; d++) begin
            for (int s = 0; s < 4; s++) begin
                chk("frame_an",  {28'd0, bus.an}, {28'd0, 4'(~(4'b0001 << d))});
                chk("frame_seg", {25'd0, bus.seg}, {25'd0, ex[d]});
                chk("frame_fd",  {31'd0, bus.frame_done},
                    {31'd0, (d == 0 && s == 0) ? fd_first : 1'b0});
                step();
            end
        end
    endtask

    initial begin
        logic [6:0] t4321 [4];
        int slot;
        int frm;
        logic [6:0] exp_seg;

        t4321[0] = S1; t4321[1] = S2; t4321[2] = S3; t4321[3] = S4;
        n_checks = 0; n_pass = 0; n_fail = 0; cyc = 0;
        reset = 1'b1;
        bus.value = '0;
        bus.load = 1'b0;
        bus.blank_mask = '0;
        bus.blink_en = 1'b0;

        // 1. Reset state and scan order
        repeat (3) @(negedge clk);
        chk("rst_seg", {25'd0, bus.seg}, {25'd0, SOFF});
        chk("rst_an",  {28'd0, bus.an}, 32'hF);
        chk("rst_fd",  {31'd0, bus.frame_done}, 32'd0);
        reset = 1'b0;
        cyc = 0;
        step();
        for (int i = 0; i < 32; i++) begin
            slot = ((cyc - 1) / 4) % 4;
            chk("scan_an",  {28'd0, bus.an}, {28'd0, 4'(~(4'b0001 << slot))});
            chk("scan_seg", {25'd0, bus.seg}, {25'd0, (slot == 0) ? S0 : SOFF});
            chk("scan_fd",  {31'd0, bus.frame_done},
                {31'd0, (cyc > 1 && ((cyc - 1) % 16) == 0)});
            step();
        end

        // 2. Full-value decode
        bus.value = 16'h1259; bus.load = 1'b1; step(); bus.load = 1'b0;
        wait_frame();
        check_frame(1'b1, S9, S5, S2, S1);

        // 3. Leading-zero blanking
        bus.value = 16'h0007; bus.load = 1'b1; step(); bus.load = 1'b0;
        wait_frame();
        check_frame(1'b1, S7, SOFF, SOFF, SOFF);
        bus.value = 16'h0000; bus.load = 1'b1; step(); bus.load = 1'b0;
        wait_frame();
        check_frame(1'b1, S0, SOFF, SOFF, SOFF);

        // 4. Tear-free load: two loads in one frame, old value held meanwhile
        step();
        bus.value = 16'h1234; bus.load = 1'b1; step(); bus.load = 1'b0;
        chk("tear_old0", {25'd0, bus.seg}, {25'd0, S0});
        bus.value = 16'h5678; bus.load = 1'b1;
        chk("tear_old1", {25'd0, bus.seg}, {25'd0, S0});
        step(); bus.load = 1'b0;
        wait_frame();
        check_frame(1'b1, S8, S7, S6, S5);

        // 5. Load exactly on the frame-boundary cycle
        repeat (14) step();
        bus.value = 16'h4321; bus.load = 1'b1; step(); bus.load = 1'b0;
        step();
        check_frame(1'b1, S1, S2, S3, S4);

        // 6a. Blink: frames 12,13 visible, 14,15 dark
        bus.blink_en = 1'b1;
        step();
        while (cyc < 257) begin
            slot = ((cyc - 1) / 4) % 4;
            frm  = (cyc - 1) / 16;
            exp_seg = (((frm / 2) % 2) == 1) ? SOFF : t4321[slot];
            chk("blink_an",  {28'd0, bus.an}, {28'd0, 4'(~(4'b0001 << slot))});
            chk("blink_seg", {25'd0, bus.seg}, {25'd0, exp_seg});
            step();
        end

        // 6b. Mask digit 1; second frame falls in an off phase with blink disabled
        bus.blink_en = 1'b0;
        bus.blank_mask = 4'b0010;
        bus.value = 16'h8888; bus.load = 1'b1; step(); bus.load = 1'b0;
        wait_frame();
        check_frame(1'b1, S8, SOFF, S8, S8);
        check_frame(1'b1, S8, SOFF, S8, S8);

        // 6c. Non-BCD code on digit 1
        bus.blank_mask = 4'b0000;
        bus.value = 16'h00A5; bus.load = 1'b1; step(); bus.load = 1'b0;
        wait_frame();
        check_frame(1'b1, S5, SOFF, SOFF, SOFF);

        // 7. Mid-frame reset discards a pending load
        repeat (3) step();
        bus.value = 16'h9999; bus.load = 1'b1; step(); bus.load = 1'b0;
        reset = 1'b1;
        step();
        chk("mrst_seg", {25'd0, bus.seg}, {25'd0, SOFF});
        chk("mrst_an",  {28'd0, bus.an}, 32'hF);
        chk("mrst_fd",  {31'd0, bus.frame_done}, 32'd0);
        reset = 1'b0;
        cyc = 0;
        step();
        check_frame(1'b0, S0, SOFF, SOFF, SOFF);
        check_frame(1'b1, S0, SOFF, SOFF, SOFF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
